// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared definitions for the 7-bit ASCII UART link (frame layout,
//          receiver state encoding, parity helper).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS  = 7;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ============================================================================
// Module : uart_receiver_if
// Brief  : Serial input and character hand-off bundle of the UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_receiver_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 data_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx,
    input  data_ready,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module : uart_rx_sync
// Brief  : Flop chain bringing the asynchronous rx pin into sys_clk; resets
//          to the idle-high line level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic sys_clk,
  input  wire logic reset,
  input  wire logic rx,
  output logic      rx_s
);

  logic [SYNC_STAGES-1:0] r_sync;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) r_sync <= 1'b1;
        else       r_sync <= rx;
      end
    end else begin : g_chain
      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      end
    end
  endgenerate

  assign rx_s = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module : uart_receiver
// Brief  : 7E1 UART receiver with mid-bit sampling and a one-entry
//          valid/ready holding register carrying per-character error flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  wire logic        sys_clk,
  input  wire logic        reset,
  uart_receiver_if.master  bus
);

  localparam int c_CNT_W   = $clog2(CLKS_PER_BIT) + 1;
  localparam int c_HALF    = (CLKS_PER_BIT - 1) / 2;
  localparam int c_HALF_M1 = (c_HALF > 0) ? c_HALF - 1 : 0;

  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_FIRST  = c_CNT_W'(c_HALF_M1);
  localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);
  localparam logic [2:0]         c_IDX_LAST = 3'(DATA_BITS - 1);

  logic w_rx_s;

  rx_state_t              r_state, w_state_next;
  logic [c_CNT_W-1:0]     r_cnt,   w_cnt_next;
  logic [2:0]             r_idx,   w_idx_next;
  logic                   w_tick;
  logic                   w_shift_en;
  logic                   w_par_en;
  logic                   w_stop_en;

  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .rx      (bus.rx),
    .rx_s    (w_rx_s)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // r_cnt counts down to the next sample instant; a bit is sampled when it hits 0.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_stop_en    = 1'b0;
    w_tick       = (r_cnt == '0);

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_idx_next = '0;
          if (c_HALF == 0) begin
            // Start bit is sampled in this very cycle; it is already known low.
            w_state_next = ST_DATA;
            w_cnt_next   = c_RELOAD;
          end else begin
            w_state_next = ST_START;
            w_cnt_next   = c_FIRST;
          end
        end
      end

      ST_START: begin
        if (w_tick) begin
          w_cnt_next   = c_RELOAD;
          w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_next = r_cnt - c_CNT_1;
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_cnt_next = c_RELOAD;
          if (r_idx == c_IDX_LAST) w_state_next = ST_PARITY;
          else                     w_idx_next   = r_idx + 3'd1;
        end else begin
          w_cnt_next = r_cnt - c_CNT_1;
        end
      end

      ST_PARITY: begin
        if (w_tick) begin
          w_par_en     = 1'b1;
          w_cnt_next   = c_RELOAD;
          w_state_next = ST_STOP;
        end else begin
          w_cnt_next = r_cnt - c_CNT_1;
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          w_stop_en    = 1'b1;
          w_cnt_next   = '0;
          w_state_next = w_rx_s ? ST_IDLE : ST_BREAK;
        end else begin
          w_cnt_next = r_cnt - c_CNT_1;
        end
      end

      ST_BREAK: begin
        if (w_rx_s) w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  // Shift register and one-entry holding register. A load in the same cycle
  // as an accept wins over the clear.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;

      if (w_shift_en) r_shift[r_idx] <= w_rx_s;
      if (w_par_en)   r_perr         <= w_rx_s ^ calc_parity(r_shift);

      if (r_valid && bus.data_ready) r_valid <= 1'b0;

      if (w_stop_en) begin
        if (!r_valid || bus.data_ready) begin
          r_data       <= r_shift;
          r_parity_err <= r_perr;
          r_frame_err  <= ~w_rx_s;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
